// File: rtl/sha_pkg.sv
// Shared definitions for the SHA hashing block.
//   mode_t       : algorithm selector used on requester and engine ports.
//   arb_state_t  : sha_arbiter control states.
//   *_MAX_LEN    : largest single-block payload (bytes) each mode can pad.
//   max_len()    : maps a mode to its single-block byte limit.
package sha;

  typedef enum logic [1:0] {
    SHA1   = 2'd0,
    SHA256 = 2'd1,
    SHA512 = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One 512-bit block holds 64 bytes minus 9 bytes of padding/length;
  // one 1024-bit block holds 128 bytes minus 17.
  localparam int SHA1_MAX_LEN   = 55;
  localparam int SHA256_MAX_LEN = 55;
  localparam int SHA512_MAX_LEN = 111;

  // Byte limit for a single-block job; an unknown encoding gets the
  // strictest limit.
  function automatic logic [31:0] max_len(input mode_t m);
    case (m)
      SHA1:    return 32'(SHA1_MAX_LEN);
      SHA256:  return 32'(SHA256_MAX_LEN);
      SHA512:  return 32'(SHA512_MAX_LEN);
      default: return 32'(SHA1_MAX_LEN);
    endcase
  endfunction

endpackage

// File: rtl/sha_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester.
//   ptr : highest-priority index for this pick.
//   gnt : one-hot grant (all zero when req is zero).
//   idx : binary index of the granted requester (zero when none).
module sha_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  int               j;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from ptr upward, wrapping, and keep the first set request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end else begin
        j = j;
      end
      cand = IDX_W'(j);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sha_arbiter.sv
// Round-robin scheduler sharing one sha_engine between N_REQ requesters.
//   clk, rst                   : clock, synchronous active-high reset.
//   req_valid/mode/msg/len     : per-requester single-block job request.
//   req_ready                  : one-hot accept strobe (combinational, IDLE only).
//   rsp_valid/rsp_ready        : one-hot response handshake to the job's owner.
//   rsp_digest, rsp_err        : shared result; err = length reject or timeout.
//   eng_valid/mode/msg/len     : start strobe and held job fields to the engine.
//   eng_ready, eng_digest      : engine idle/done and its result.
module sha_arbiter
  import sha::*;
#(
  parameter int N_REQ   = 4,
  parameter int MSG_W   = 1024,
  parameter int LEN_W   = 8,
  parameter int DIG_W   = 512,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  mode_t [N_REQ-1:0]            req_mode,
  input  logic [N_REQ-1:0][MSG_W-1:0]  req_msg,
  input  logic [N_REQ-1:0][LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [DIG_W-1:0]             rsp_digest,
  output logic                         rsp_err,
  output logic                         eng_valid,
  output mode_t                        eng_mode,
  output logic [MSG_W-1:0]             eng_msg,
  output logic [LEN_W-1:0]             eng_len,
  input  logic                         eng_ready,
  input  logic [DIG_W-1:0]             eng_digest
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, job_idx, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             started;
  logic [WD_W-1:0]  wd, wd_inc;
  logic             len_bad, done, timeout;
  mode_t            sel_mode;
  logic [LEN_W-1:0] sel_len;

  sha_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign sel_mode = req_mode[pick_idx];
  assign sel_len  = req_len[pick_idx];
  assign len_bad  = 32'(sel_len) > max_len(sel_mode);
  // started keeps a stale eng_ready=1 from being mistaken for completion.
  assign done     = started & eng_ready;
  // wd holds completed BUSY cycles; wd_inc includes the current one.
  assign wd_inc   = wd + WD_W'(1);
  assign timeout  = (wd_inc == WD_W'(TIMEOUT));

  // Next-state decode and the combinational accept strobe.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = pick_gnt;
          state_nxt = len_bad ? RESP : ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = BUSY;
      BUSY: begin
        if (done || timeout) begin
          state_nxt = RESP;
        end else begin
          state_nxt = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready[job_idx]) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, job registers, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      job_idx    <= '0;
      started    <= 1'b0;
      wd         <= '0;
      eng_valid  <= 1'b0;
      eng_mode   <= SHA1;
      eng_msg    <= '0;
      eng_len    <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_digest <= '0;
    end else begin
      state     <= state_nxt;
      eng_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            job_idx  <= pick_idx;
            eng_mode <= sel_mode;
            eng_msg  <= req_msg[pick_idx];
            eng_len  <= sel_len;
            if (len_bad) begin
              rsp_valid  <= pick_gnt;
              rsp_err    <= 1'b1;
              rsp_digest <= '0;
            end else begin
              eng_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          started <= 1'b0;
          wd      <= '0;
        end
        BUSY: begin
          wd <= wd_inc;
          if (!eng_ready) begin
            started <= 1'b1;
          end
          // Completion takes precedence over a simultaneous timeout.
          if (done) begin
            rsp_valid  <= {{(N_REQ-1){1'b0}}, 1'b1} << job_idx;
            rsp_err    <= 1'b0;
            rsp_digest <= eng_digest;
          end else if (timeout) begin
            rsp_valid  <= {{(N_REQ-1){1'b0}}, 1'b1} << job_idx;
            rsp_err    <= 1'b1;
            rsp_digest <= '0;
          end
        end
        RESP: begin
          if (rsp_ready[job_idx]) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            ptr       <= (job_idx == IDX_W'(N_REQ - 1)) ? '0 : job_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_arbiter.sv
module tb_sha_arbiter;
  import sha::*;

  localparam int N     = 4;
  localparam int MSG_W = 1024;
  localparam int LEN_W = 8;
  localparam int DIG_W = 512;
  localparam int TO    = 15;
  localparam int LAT   = 6;

  localparam logic [DIG_W-1:0] D256 =
    512'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [DIG_W-1:0] D1 = 512'h2aae6c35c94fcfb415dbe95f408b9ce91ee846ed;
  localparam logic [MSG_W-1:0] HELLO = 1024'h68656C6C6F20776F726C64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [N-1:0]                req_valid, req_ready, rsp_valid, rsp_ready;
  mode_t [N-1:0]               req_mode;
  logic [N-1:0][MSG_W-1:0]     req_msg;
  logic [N-1:0][LEN_W-1:0]     req_len;
  logic [DIG_W-1:0]            rsp_digest, eng_digest;
  logic                        rsp_err, eng_valid, eng_ready;
  mode_t                       eng_mode;
  logic [MSG_W-1:0]            eng_msg;
  logic [LEN_W-1:0]            eng_len;

  int n_tests = 0;
  int n_fail  = 0;

  sha_arbiter #(.N_REQ(N), .MSG_W(MSG_W), .LEN_W(LEN_W), .DIG_W(DIG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_msg(req_msg), .req_len(req_len),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_digest(rsp_digest), .rsp_err(rsp_err),
    .eng_valid(eng_valid), .eng_mode(eng_mode), .eng_msg(eng_msg), .eng_len(eng_len),
    .eng_ready(eng_ready), .eng_digest(eng_digest)
  );

  // Engine stand-in: knows the two reference digests, otherwise a fold of the input.
  function automatic logic [DIG_W-1:0] engine_result(input mode_t m, input logic [MSG_W-1:0] msg,
                                                     input logic [LEN_W-1:0] len);
    if (msg == HELLO && len == 8'd11 && m == SHA256) return D256;
    else if (msg == HELLO && len == 8'd11 && m == SHA1) return D1;
    else return msg[511:0] ^ msg[1023:512] ^ {len, 502'd0, m};
  endfunction

  function automatic int model_max(input mode_t m);
    return (m == SHA512) ? 111 : 55;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] p, input int start);
    for (int k = 0; k < N; k++) begin
      if (p[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Behavioural engine: LAT cycles busy after a start, or never busy when stuck.
  logic             stuck = 1'b0;
  int               eng_cnt;
  int               eng_starts = 0;
  mode_t            em;
  logic [MSG_W-1:0] emsg;
  logic [LEN_W-1:0] elen;
  always @(posedge clk) begin
    if (rst) begin
      eng_ready  <= 1'b1;
      eng_cnt    <= 0;
      eng_digest <= '0;
    end else begin
      if (eng_valid) eng_starts <= eng_starts + 1;
      if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_ready  <= 1'b1;
          eng_digest <= engine_result(em, emsg, elen);
        end
      end else if (eng_valid && !stuck) begin
        eng_ready <= 1'b0;
        eng_cnt   <= LAT;
        em        <= eng_mode;
        emsg      <= eng_msg;
        elen      <= eng_len;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},  512'(req_ready),  512'(0));
    check({tag, "_rsp_valid"},  512'(rsp_valid),  512'(0));
    check({tag, "_eng_valid"},  512'(eng_valid),  512'(0));
    check({tag, "_rsp_err"},    512'(rsp_err),    512'(0));
    check({tag, "_rsp_digest"}, rsp_digest,       512'(0));
    check({tag, "_eng_msg"},    eng_msg[511:0] | eng_msg[1023:512], 512'(0));
    check({tag, "_eng_len"},    512'(eng_len),    512'(0));
    check({tag, "_eng_mode"},   512'(eng_mode),   512'(SHA1));
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (rsp_valid == '0 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    int cyc = 0;
    #1;
    while (req_ready == '0 && cyc < 100) begin
      step();
      cyc++;
    end
    g = req_ready;
  endtask

  // One isolated job from accept through response handshake.
  task automatic run_job(input int idx, input mode_t m, input logic [MSG_W-1:0] msg,
                         input logic [LEN_W-1:0] len, input logic exp_err,
                         input logic [DIG_W-1:0] exp_dig, input int exp_lat, input int exp_starts);
    int           starts0, cyc;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    starts0 = eng_starts;
    req_mode[idx] = m; req_msg[idx] = msg; req_len[idx] = len; req_valid[idx] = 1'b1;
    #1;
    check("accept_ready", 512'(req_ready), 512'(oh));
    step();
    req_valid[idx] = 1'b0;
    check("issue_eng_valid", 512'(eng_valid), 512'(exp_starts));
    if (exp_starts != 0) begin
      check("issue_eng_len", 512'(eng_len), 512'(len));
      check("issue_eng_mode", 512'(eng_mode), 512'(m));
    end
    wait_rsp(cyc);
    check("rsp_latency", 512'(cyc), 512'(exp_lat));
    check("rsp_valid", 512'(rsp_valid), 512'(oh));
    check("rsp_err", 512'(rsp_err), 512'(exp_err));
    check("rsp_digest", rsp_digest, exp_dig);
    check("eng_starts", 512'(eng_starts - starts0), 512'(exp_starts));
    rsp_ready[idx] = 1'b1;
    step();
    rsp_ready[idx] = 1'b0;
    check("rsp_drop", 512'(rsp_valid), 512'(0));
  endtask

  typedef struct {
    int               idx;
    mode_t            m;
    logic [LEN_W-1:0] len;
    logic             err;
    logic [DIG_W-1:0] dig;
    int               lat;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs[8];
    logic [N-1:0] g;
    int           cyc, order[5], mptr, jobs_done, exp_starts, starts0, cur_g, exp_g, rv_seen;
    logic         cur_err;
    logic [DIG_W-1:0] cur_dig;
    logic [N-1:0] grant_mask;
    int           bnd[6];

    vecs[0] = '{0, SHA256, 8'd11,  1'b0, D256, LAT + 3};
    vecs[1] = '{1, SHA1,   8'd11,  1'b0, D1,   LAT + 3};
    vecs[2] = '{2, SHA256, 8'd56,  1'b1, '0,   1};
    vecs[3] = '{3, SHA512, 8'd112, 1'b1, '0,   1};
    vecs[4] = '{0, SHA512, 8'd111, 1'b0, engine_result(SHA512, HELLO, 8'd111), LAT + 3};
    vecs[5] = '{1, SHA1,   8'd55,  1'b0, engine_result(SHA1, HELLO, 8'd55), LAT + 3};
    vecs[6] = '{2, SHA1,   8'd56,  1'b1, '0,   1};
    vecs[7] = '{3, SHA512, 8'd0,   1'b0, engine_result(SHA512, HELLO, 8'd0), LAT + 3};

    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_mode = '0; req_msg = '0; req_len = '0;
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Stuck engine: watchdog fires 16 cycles after ISSUE (accept + 17).
    stuck = 1'b1;
    run_job(0, SHA256, HELLO, 8'd11, 1'b1, '0, TO + 2, 1);
    stuck = 1'b0;
    step();

    // Table: digests, length boundaries, reject latency; ends with ptr back at 0.
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].idx, vecs[i].m, HELLO, vecs[i].len, vecs[i].err, vecs[i].dig,
              vecs[i].lat, vecs[i].err ? 0 : 1);
    end

    // All four at once; requester 0 re-asserts after its response.
    for (int i = 0; i < N; i++) begin
      req_mode[i] = SHA1; req_msg[i] = HELLO; req_len[i] = 8'd11;
    end
    req_valid = 4'hF;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("rr_order", 512'(g), 512'(N'(1) << order[k]));
      step();
      req_valid = req_valid & ~g;
      wait_rsp(cyc);
      check("rr_rsp_valid", 512'(rsp_valid), 512'(g));
      check("rr_digest", rsp_digest, D1);
      rsp_ready = g;
      step();
      rsp_ready = '0;
      if (k == 0) req_valid[0] = 1'b1;
    end

    // Response back-pressure with requester 2 waiting; ptr is now 1.
    req_mode[1] = SHA256; req_msg[1] = HELLO; req_len[1] = 8'd11; req_valid[1] = 1'b1;
    wait_grant(g);
    check("stall_grant", 512'(g), 512'(4'b0010));
    step();
    req_valid[1] = 1'b0;
    req_mode[2] = SHA1; req_msg[2] = HELLO; req_len[2] = 8'd11; req_valid[2] = 1'b1;
    wait_rsp(cyc);
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stall_digest", rsp_digest, D256);
      check("stall_no_accept", 512'(req_ready), 512'(0));
      check("stall_rsp_valid", 512'(rsp_valid), 512'(4'b0010));
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    check("pending_accept", 512'(req_ready), 512'(4'b0100));
    step();
    req_valid[2] = 1'b0;
    wait_rsp(cyc);
    check("pending_digest", rsp_digest, D1);
    check("pending_rsp_valid", 512'(rsp_valid), 512'(4'b0100));
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;

    // Reset in BUSY abandons the job.
    req_mode[3] = SHA256; req_msg[3] = HELLO; req_len[3] = 8'd11; req_valid[3] = 1'b1;
    wait_grant(g);
    step();
    req_valid[3] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset("midreset");
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid != '0 || eng_valid) rv_seen++;
      step();
    end
    check("midreset_quiet", 512'(rv_seen), 512'(0));
    run_job(1, SHA256, HELLO, 8'd11, 1'b0, D256, LAT + 3, 1);

    // Randomized traffic against a transaction-level round-robin model.
    bnd = '{54, 55, 56, 110, 111, 112};
    mptr = 2; jobs_done = 0; exp_starts = 0; cyc = 0; cur_g = 0; cur_err = 1'b0; cur_dig = '0;
    starts0 = eng_starts;
    while (jobs_done < 150 && cyc < 30000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_mode[i] = mode_t'($urandom_range(2));
          req_len[i]  = ($urandom_range(1) == 0) ? LEN_W'(bnd[$urandom_range(5)])
                                                 : LEN_W'($urandom_range(127));
          for (int w = 0; w < MSG_W / 32; w++) req_msg[i][w*32 +: 32] = $urandom;
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = N'($urandom);
      #1;
      grant_mask = '0;
      if (req_ready != '0) begin
        exp_g = rr_pick(req_valid, mptr);
        check("rand_grant", 512'(req_ready), 512'(N'(1) << exp_g));
        cur_g   = exp_g;
        cur_err = int'(req_len[exp_g]) > model_max(req_mode[exp_g]);
        cur_dig = cur_err ? '0 : engine_result(req_mode[exp_g], req_msg[exp_g], req_len[exp_g]);
        if (!cur_err) exp_starts++;
        grant_mask = req_ready;
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        check("rand_rsp_valid", 512'(rsp_valid), 512'(N'(1) << cur_g));
        check("rand_rsp_err", 512'(rsp_err), 512'(cur_err));
        check("rand_rsp_digest", rsp_digest, cur_dig);
        mptr = (cur_g + 1) % N;
        jobs_done++;
      end
      step();
      cyc++;
      req_valid = req_valid & ~grant_mask;
    end
    check("rand_jobs_done", 512'(jobs_done), 512'(150));
    check("rand_eng_starts", 512'(eng_starts - starts0), 512'(exp_starts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
